suspect_strings_arbiter: RTL and testbench
==========================================

// Module: suspect_strings_arbiter
// PURPOSE
//  Shares one downstream suspect-string path between all bloom_search_engine outputs.
//  Requesters: ENGINES x STR_SIZES flattened streams, index r = engine*STR_SIZES + (len-MIN_STR_SIZE).
//  Round-robin grant, one registered output stage, ready/valid on both sides.
//  Counts forwarded strings for CSR readout.
//  Sits between the bloom_engine_gen array and the output FIFO / AST source packer.
// PARAMETERS
//  BYTE_W        8   bits per symbol
//  ENGINES       8   number of search engines (= AST_SINK_SYMBOLS)
//  MIN_STR_SIZE  3   shortest checked string, bytes
//  MAX_STR_SIZE  8   longest checked string, bytes; also the data width in bytes
//  CNT_W         32  forwarded-string counter width (= AMM_CSR_DATA_W)
//  derived: STR_SIZES=MAX_STR_SIZE-MIN_STR_SIZE+1, REQ_N=ENGINES*STR_SIZES,
//           REQ_W=$clog2(REQ_N), ENG_W=max(1,$clog2(ENGINES)), LEN_W=$clog2(MAX_STR_SIZE)+1
// PORTS
//  clk_i            in   1                           single clock, all logic
//  srst_n_i         in   1                           synchronous reset, active-low
//  req_data_i       in   [REQ_N][MAX_STR_SIZE][BYTE_W] per-requester string, byte 0 = first
//  req_valid_i      in   REQ_N                       per-requester valid
//  req_ready_o      out  REQ_N                       per-requester ready, at most one bit set
//  out_data_o       out  [MAX_STR_SIZE][BYTE_W]      granted string; bytes >= out_len_o are don't-care
//  out_len_o        out  LEN_W                       string length, MIN_STR_SIZE..MAX_STR_SIZE
//  out_engine_o     out  ENG_W                       source engine index
//  out_valid_o      out  1                           output valid
//  out_ready_i      in   1                           downstream ready
//  fwd_cnt_o        out  CNT_W                       strings forwarded since reset/clear
//  fwd_cnt_clr_i    in   1                           one-cycle clear strobe
// BEHAVIOUR
//  - Reset (srst_n_i=0 at a clock edge): out_valid_o=0; out_data_o, out_len_o, out_engine_o=0;
//    rr_ptr=0; fwd_cnt_o=0. A held output is discarded. req_ready_o=0 while srst_n_i=0 (combinational).
//  - load = !out_valid_o || out_ready_i. The output register accepts a new string only when load=1.
//  - Grant (combinational): if load, g = first r with req_valid_i[r]=1 searching
//    rr_ptr, rr_ptr+1, ..., REQ_N-1, 0, ..., rr_ptr-1. req_ready_o = onehot(g).
//    If !load or no valid requester, req_ready_o = '0.
//  - On a grant edge: out_data_o<=req_data_i[g]; out_len_o<=MIN_STR_SIZE+(g%STR_SIZES);
//    out_engine_o<=g/STR_SIZES; out_valid_o<=1; rr_ptr<=(g==REQ_N-1)?0:g+1.
//  - Load with no valid requester: out_valid_o<=0; data/len/engine hold.
//  - !load (out_valid_o=1, out_ready_i=0): all outputs hold, rr_ptr holds.
//  - Latency: request accepted at edge N appears on out_* after edge N (1 cycle).
//    Back-to-back throughput is 1 string/cycle while out_ready_i=1.
//  - Fairness: a requester holding valid is granted within REQ_N grants.
//  - Requesters must keep valid and data stable until ready (AST rule); the arbiter does not re-check.
//  - fwd_cnt_o increments on each downstream handshake (out_valid_o && out_ready_i) and
//    saturates at 2^CNT_W-1. Clear with a handshake in the same cycle -> 1. Clear alone -> 0.
//  - REQ_N==1: rr_ptr stays 0; grant is simply req_valid_i[0] && load.
// STRUCTURE
//  - bloom_filter_pkg: add function str_sizes(), typedef suspect_str_t
//    ([MAX_STR_SIZE-1:0][BYTE_W-1:0]), and localparams REQ_N/LEN_W for top-level wiring.
//  - Sub-module rr_arbiter #(N): inputs req, en, ptr; output onehot grant, grant_idx, any.
//    Rotate / priority-encode / rotate back. Purely combinational.
//    This module holds rr_ptr, the output register and the counter.
// TESTING
//  1) Reset: srst_n_i=0 while req_valid_i='1 -> req_ready_o=0, out_valid_o=0, fwd_cnt_o=0.
//  2) Single req r=5 (ENGINES=8, sizes 3..8) with out_ready_i=1 -> next cycle out_engine_o=0,
//     out_len_o=8, data matches, fwd_cnt_o=1 after handshake.
//  3) All REQ_N valid, out_ready_i=1 for 2*REQ_N cycles -> grant order 0,1,...,REQ_N-1,0,...;
//     each requester granted exactly twice.
//  4) out_ready_i=0 for 10 cycles with out_valid_o=1 -> out_* stable, req_ready_o='0.
//     Release -> next grant follows the held one in rr order.
//  5) Counter: preload to 2^CNT_W-2, 3 handshakes -> saturates at 2^CNT_W-1.
//     fwd_cnt_clr_i with a handshake -> 1; clear alone -> 0.
//  6) srst_n_i=0 while out_valid_o=1 and out_ready_i=0 -> output dropped; after release rr_ptr=0,
//     so req 0 wins over req 7 when both are valid.

Source files
------------

// File: rtl/suspect_strings_arbiter_pkg.sv
// Shared sizing, string type and helpers for the suspect-string arbiter slice.
package suspect_strings_arbiter_pkg;

   localparam int unsigned BYTE_W       = 8;
   localparam int unsigned ENGINES      = 8;
   localparam int unsigned MIN_STR_SIZE = 3;
   localparam int unsigned MAX_STR_SIZE = 8;
   localparam int unsigned DEF_CNT_W    = 32;

   function automatic int unsigned str_sizes(input int unsigned min_size,
                                             input int unsigned max_size);
      return max_size - min_size + 1;
   endfunction

   localparam int unsigned STR_SIZES = str_sizes(MIN_STR_SIZE, MAX_STR_SIZE);
   localparam int unsigned REQ_N     = ENGINES * STR_SIZES;
   localparam int unsigned REQ_W     = (REQ_N > 1) ? $clog2(REQ_N) : 1;
   localparam int unsigned ENG_W     = (ENGINES > 1) ? $clog2(ENGINES) : 1;
   localparam int unsigned LEN_W     = $clog2(MAX_STR_SIZE) + 1;

   typedef logic [MAX_STR_SIZE-1:0][BYTE_W-1:0] suspect_str_t;

endpackage

// File: rtl/suspect_strings_arbiter_if.sv
// Requester, downstream and counter signals of the suspect-string arbiter.
interface suspect_strings_arbiter_if #(
   parameter int unsigned CNT_W = suspect_strings_arbiter_pkg::DEF_CNT_W
);
   import suspect_strings_arbiter_pkg::*;

   suspect_str_t [REQ_N-1:0] req_data_i;
   logic [REQ_N-1:0]         req_valid_i;
   logic [REQ_N-1:0]         req_ready_o;
   suspect_str_t             out_data_o;
   logic [LEN_W-1:0]         out_len_o;
   logic [ENG_W-1:0]         out_engine_o;
   logic                     out_valid_o;
   logic                     out_ready_i;
   logic [CNT_W-1:0]         fwd_cnt_o;
   logic                     fwd_cnt_clr_i;

   // master: requesters + downstream sink + CSR; slave: the arbiter
   modport master (
      output req_data_i, req_valid_i, out_ready_i, fwd_cnt_clr_i,
      input  req_ready_o, out_data_o, out_len_o, out_engine_o, out_valid_o, fwd_cnt_o
   );

   modport slave (
      input  req_data_i, req_valid_i, out_ready_i, fwd_cnt_clr_i,
      output req_ready_o, out_data_o, out_len_o, out_engine_o, out_valid_o, fwd_cnt_o
   );

endinterface

// File: rtl/suspect_strings_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests by ptr, pick lowest, rotate back.
module suspect_strings_arbiter_rr_arbiter #(
   parameter int unsigned N  = 4,
   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic          en_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [PW-1:0] grant_idx_o,
   output logic          any_o
);

   logic [N-1:0]  rot;
   logic [PW-1:0] pe;
   logic          found;
   logic [PW:0]   sum;

   always_comb begin
      rot = '0;
      for (int unsigned i = 0; i < N; i++) begin
         int unsigned idx;
         idx = i + int'(ptr_i);
         if (idx >= N) idx = idx - N;
         rot[i] = req_i[idx];
      end

      pe    = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && rot[i]) begin
            pe    = PW'(i);
            found = 1'b1;
         end
      end

      sum = {1'b0, pe} + {1'b0, ptr_i};
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);

      any_o       = en_i && found;
      grant_idx_o = sum[PW-1:0];
      grant_o     = '0;
      if (any_o) grant_o[grant_idx_o] = 1'b1;
   end

endmodule

// File: rtl/suspect_strings_arbiter.sv
// Round-robin merge of all bloom engine suspect strings into one registered
// ready/valid output stage, with a saturating forwarded-string counter.
module suspect_strings_arbiter
   import suspect_strings_arbiter_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic                      clk_i,
   input  logic                      srst_n_i,
   suspect_strings_arbiter_if.slave  bus
);

   suspect_str_t      data_q, data_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [ENG_W-1:0]  engine_q, engine_d;
   logic              valid_q, valid_d;
   logic [REQ_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              load;
   logic              handshake;
   logic [REQ_N-1:0]  grant;
   logic [REQ_W-1:0]  grant_idx;
   logic              grant_any;
   int unsigned       gi;

   assign load      = !valid_q || bus.out_ready_i;
   assign handshake = valid_q && bus.out_ready_i;

   // gating with srst_n_i keeps req_ready_o low throughout reset
   suspect_strings_arbiter_rr_arbiter #(.N(REQ_N)) u_rr (
      .req_i       (bus.req_valid_i),
      .en_i        (load && srst_n_i),
      .ptr_i       (rr_ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx),
      .any_o       (grant_any)
   );

   always_comb begin
      data_d   = data_q;
      len_d    = len_q;
      engine_d = engine_q;
      valid_d  = valid_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      gi       = int'(grant_idx);

      if (load) begin
         if (grant_any) begin
            data_d   = bus.req_data_i[grant_idx];
            len_d    = LEN_W'(MIN_STR_SIZE + (gi % STR_SIZES));
            engine_d = ENG_W'(gi / STR_SIZES);
            valid_d  = 1'b1;
            rr_ptr_d = (gi == REQ_N - 1) ? '0 : REQ_W'(gi + 1);
         end else begin
            valid_d  = 1'b0;
         end
      end

      if (bus.fwd_cnt_clr_i) begin
         cnt_d = handshake ? CNT_W'(1) : '0;
      end else if (handshake && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         data_q   <= '0;
         len_q    <= '0;
         engine_q <= '0;
         valid_q  <= 1'b0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         data_q   <= data_d;
         len_q    <= len_d;
         engine_q <= engine_d;
         valid_q  <= valid_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.req_ready_o  = grant;
   assign bus.out_data_o   = data_q;
   assign bus.out_len_o    = len_q;
   assign bus.out_engine_o = engine_q;
   assign bus.out_valid_o  = valid_q;
   assign bus.fwd_cnt_o    = cnt_q;

endmodule

// File: tb/tb_suspect_strings_arbiter.sv
// Scoreboard bench for suspect_strings_arbiter: a round-robin reference model
// predicts grants and pushes expected strings, popped on downstream handshakes.
module tb_suspect_strings_arbiter;
   import suspect_strings_arbiter_pkg::*;

   localparam int unsigned TB_CNT_W = 4;
   localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;

   typedef struct {
      suspect_str_t data;
      int           len;
      int           eng;
   } exp_t;

   logic clk = 1'b0;
   logic srst_n;

   suspect_strings_arbiter_if #(.CNT_W(TB_CNT_W)) bus ();

   suspect_strings_arbiter #(.CNT_W(TB_CNT_W)) dut (
      .clk_i    (clk),
      .srst_n_i (srst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int           n_cmp = 0;
   int           n_err = 0;
   exp_t         exp_q[$];
   suspect_str_t stim_data [REQ_N];
   bit           m_valid;
   int           m_ptr;
   int           m_cnt;
   bit           count_grants;
   int           gcnt [REQ_N];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] masked(input suspect_str_t d, input int len);
      logic [63:0] m;
      m = '0;
      for (int b = 0; b < int'(MAX_STR_SIZE); b++)
         if (b < len) m[b*BYTE_W +: BYTE_W] = d[b];
      return m;
   endfunction

   // Checks at negedge, then advances the model across the next posedge.
   task automatic tick();
      logic [REQ_N-1:0] exp_rdy;
      bit   load;
      bit   hs;
      int   g;
      exp_t e;
      @(negedge clk);
      load = !m_valid || bus.out_ready_i;
      g = -1;
      if (srst_n && load) begin
         for (int i = 0; i < int'(REQ_N); i++) begin
            int idx;
            idx = (m_ptr + i) % int'(REQ_N);
            if (g < 0 && bus.req_valid_i[idx]) g = idx;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check_eq("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
      check_eq("out_valid", 64'(bus.out_valid_o), 64'(m_valid));
      if (m_valid) begin
         check_eq("sb_size", 64'(exp_q.size()), 64'd1);
         if (exp_q.size() > 0) begin
            e = exp_q[0];
            check_eq("out_data", masked(bus.out_data_o, e.len), masked(e.data, e.len));
            check_eq("out_len", 64'(bus.out_len_o), 64'(e.len));
            check_eq("out_engine", 64'(bus.out_engine_o), 64'(e.eng));
            if (bus.out_ready_i) void'(exp_q.pop_front());
         end
      end
      check_eq("fwd_cnt", 64'(bus.fwd_cnt_o), 64'(m_cnt));
      if (count_grants)
         for (int r = 0; r < int'(REQ_N); r++)
            if (bus.req_ready_o[r]) gcnt[r]++;

      @(posedge clk);
      if (!srst_n) begin
         m_valid = 1'b0;
         m_ptr   = 0;
         m_cnt   = 0;
         exp_q.delete();
      end else begin
         hs = m_valid && bus.out_ready_i;
         if (bus.fwd_cnt_clr_i) m_cnt = hs ? 1 : 0;
         else if (hs && m_cnt != CNT_MAX) m_cnt++;
         if (load) begin
            if (g >= 0) begin
               e.data = stim_data[g];
               e.len  = int'(MIN_STR_SIZE) + g % int'(STR_SIZES);
               e.eng  = g / int'(STR_SIZES);
               exp_q.push_back(e);
               m_valid = 1'b1;
               m_ptr   = (g == int'(REQ_N) - 1) ? 0 : g + 1;
            end else begin
               m_valid = 1'b0;
            end
         end
      end
      #1;
   endtask

   initial begin
      for (int r = 0; r < int'(REQ_N); r++) begin
         for (int b = 0; b < int'(MAX_STR_SIZE); b++)
            stim_data[r][b] = BYTE_W'($urandom);
         bus.req_data_i[r] = stim_data[r];
         gcnt[r] = 0;
      end
      count_grants      = 1'b0;
      srst_n            = 1'b0;
      bus.req_valid_i   = '1;
      bus.out_ready_i   = 1'b1;
      bus.fwd_cnt_clr_i = 1'b0;
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      m_ptr   = 0;
      m_cnt   = 0;

      // 1) reset with every requester valid
      tick();
      tick();
      check_eq("rst_valid", 64'(bus.out_valid_o), 64'd0);
      check_eq("rst_len", 64'(bus.out_len_o), 64'd0);
      check_eq("rst_engine", 64'(bus.out_engine_o), 64'd0);
      check_eq("rst_data", 64'(bus.out_data_o), 64'd0);
      check_eq("rst_cnt", 64'(bus.fwd_cnt_o), 64'd0);

      // 2) single requester 5 -> engine 0, length 8
      srst_n          = 1'b1;
      bus.req_valid_i = '0;
      tick();
      bus.req_valid_i[5] = 1'b1;
      tick();
      bus.req_valid_i = '0;
      check_eq("r5_engine", 64'(bus.out_engine_o), 64'd0);
      check_eq("r5_len", 64'(bus.out_len_o), 64'd8);
      check_eq("r5_data", masked(bus.out_data_o, 8), masked(stim_data[5], 8));
      tick();
      check_eq("r5_cnt", 64'(bus.fwd_cnt_o), 64'd1);

      // 3) all valid from rr_ptr=0 for 2*REQ_N cycles
      srst_n = 1'b0;
      tick();
      srst_n          = 1'b1;
      bus.req_valid_i = '1;
      count_grants    = 1'b1;
      repeat (2 * REQ_N) tick();
      count_grants    = 1'b0;
      bus.req_valid_i = '0;
      tick();
      for (int r = 0; r < int'(REQ_N); r++)
         check_eq($sformatf("grants_r%0d", r), 64'(gcnt[r]), 64'd2);

      // 4) downstream stall while holding an output
      bus.req_valid_i = '1;
      repeat (3) tick();
      bus.out_ready_i = 1'b0;
      repeat (10) tick();
      bus.out_ready_i = 1'b1;
      tick();
      check_eq("post_stall_engine", 64'(bus.out_engine_o), 64'd0);
      check_eq("post_stall_len", 64'(bus.out_len_o), 64'(MIN_STR_SIZE + 3));
      bus.req_valid_i = '0;
      tick();
      tick();

      // 5) counter preload, saturation and clear
      bus.fwd_cnt_clr_i = 1'b1;
      tick();
      bus.fwd_cnt_clr_i = 1'b0;
      check_eq("clr_idle", 64'(bus.fwd_cnt_o), 64'd0);
      bus.req_valid_i = '1;
      for (int i = 0; i < 100 && m_cnt != CNT_MAX - 1; i++) tick();
      check_eq("cnt_preload", 64'(bus.fwd_cnt_o), 64'(CNT_MAX - 1));
      repeat (3) tick();
      check_eq("cnt_sat", 64'(bus.fwd_cnt_o), 64'(CNT_MAX));
      bus.fwd_cnt_clr_i = 1'b1;
      tick();
      bus.fwd_cnt_clr_i = 1'b0;
      check_eq("clr_with_hs", 64'(bus.fwd_cnt_o), 64'd1);
      bus.req_valid_i = '0;
      tick();
      bus.fwd_cnt_clr_i = 1'b1;
      tick();
      bus.fwd_cnt_clr_i = 1'b0;
      check_eq("clr_alone", 64'(bus.fwd_cnt_o), 64'd0);

      // 6) reset drops a stalled output and rewinds rr_ptr
      bus.out_ready_i    = 1'b0;
      bus.req_valid_i[7] = 1'b1;
      tick();
      bus.req_valid_i = '0;
      tick();
      check_eq("held_engine", 64'(bus.out_engine_o), 64'd1);
      srst_n = 1'b0;
      tick();
      check_eq("drop_valid", 64'(bus.out_valid_o), 64'd0);
      srst_n             = 1'b1;
      bus.out_ready_i    = 1'b1;
      bus.req_valid_i[0] = 1'b1;
      bus.req_valid_i[7] = 1'b1;
      tick();
      bus.req_valid_i = '0;
      check_eq("rewind_engine", 64'(bus.out_engine_o), 64'd0);
      check_eq("rewind_len", 64'(bus.out_len_o), 64'(MIN_STR_SIZE));
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
